mask_grant_drain: RTL and testbench

- Sequential consumer of a request bit-mask: latches one mask, then issues the set bits lowest-index-first, up to GRANT_WIDTH bits per output beat, until the mask is empty.
- Each set bit's slot within a beat is its rank, i.e. the count of set pending bits below it.
- Used wherever the pipeline turns a valid mask into compacted per-port indices, for example dispatch or writeback port allocation.

---
 rtl/mask_grant_drain.sv | 123 ++++++++++++
 tb/tb_mask_grant_drain.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_grant_drain.sv
// mask_grant_drain: latches one request mask, then hands out its set bits
// lowest-index-first, at most GRANT_WIDTH per beat, until the mask is empty.
// Each granted bit lands in the output slot equal to its rank, which is the
// number of still-pending bits below it.
module mask_grant_drain #(
  parameter int NUM_INPUT   = 8,
  parameter int GRANT_WIDTH = 2,
  parameter int IDX_SIZE    = $clog2(NUM_INPUT)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_INPUT-1:0]            in_mask,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_INPUT-1:0]            out_grant,
  output logic [GRANT_WIDTH*IDX_SIZE-1:0] out_idx,
  output logic [GRANT_WIDTH-1:0]          out_idx_valid,
  output logic                            out_last
);

  // Popcounts never exceed NUM_INPUT, so this width cannot overflow.
  localparam int CW = $clog2(NUM_INPUT + 1);
  localparam logic [CW-1:0] GW_C = CW'(GRANT_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [NUM_INPUT-1:0]            r_pending;
  logic [NUM_INPUT-1:0]            w_pending_next;
  logic [CW-1:0]                   w_rank [NUM_INPUT];
  logic [CW-1:0]                   w_total;
  logic [NUM_INPUT-1:0]            w_grant;
  logic [GRANT_WIDTH*IDX_SIZE-1:0] w_idx;
  logic [GRANT_WIDTH-1:0]          w_idx_valid;
  logic                            w_drain;
  logic                            w_last;

  function automatic logic [CW-1:0] popcnt(input logic [NUM_INPUT-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int j = 0; j < NUM_INPUT; j++) begin
      s = s + CW'(v[j]);
    end
    return s;
  endfunction

  assign w_drain = (r_state == DRAIN);
  assign w_total = popcnt(r_pending);
  assign w_last  = w_drain && (w_total <= GW_C);

  // Per-bit rank and grant: a pending bit is granted while its rank fits a slot.
  for (genvar gi = 0; gi < NUM_INPUT; gi++) begin : g_rank
    localparam logic [NUM_INPUT-1:0] LOW_MASK = NUM_INPUT'((64'd1 << gi) - 64'd1);
    assign w_rank[gi]  = popcnt(r_pending & LOW_MASK);
    assign w_grant[gi] = w_drain && r_pending[gi] && (w_rank[gi] < GW_C);
  end

  // Per-slot index: slot k carries the pending bit whose rank equals k.
  for (genvar gk = 0; gk < GRANT_WIDTH; gk++) begin : g_slot
    logic [IDX_SIZE-1:0] w_slot;

    // Select the one pending bit of rank gk; empty slots stay at zero.
    always_comb begin
      w_slot = '0;
      for (int i = 0; i < NUM_INPUT; i++) begin
        if (w_drain && r_pending[i] && (w_rank[i] == CW'(gk))) begin
          w_slot = IDX_SIZE'(i);
        end
      end
    end

    assign w_idx[gk*IDX_SIZE +: IDX_SIZE] = w_slot;
    assign w_idx_valid[gk]                = w_drain && (w_total > CW'(gk));
  end

  // State and pending mask; reset discards any partially drained mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  // Next state: accept a non-empty mask in IDLE, retire granted bits on transfer.
  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    case (r_state)
      IDLE: begin
        if (in_valid && (in_mask != '0)) begin
          w_pending_next = in_mask;
          w_state_next   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          w_pending_next = r_pending & ~w_grant;
          if (w_last) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign in_ready      = !w_drain;
  assign out_valid     = w_drain;
  assign out_grant     = w_grant;
  assign out_idx       = w_idx;
  assign out_idx_valid = w_idx_valid;
  assign out_last      = w_last;

endmodule

// File: tb/tb_mask_grant_drain.sv
// Bench for mask_grant_drain: a queue-of-beats model plus directed scenarios.
module tb_mask_grant_drain;
  localparam int N  = 8;
  localparam int G  = 2;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_mask = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_grant;
  logic [G*IW-1:0]  out_idx;
  logic [G-1:0]     out_idx_valid;
  logic             out_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mask_grant_drain #(.NUM_INPUT(N), .GRANT_WIDTH(G), .IDX_SIZE(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_grant(out_grant), .out_idx(out_idx),
    .out_idx_valid(out_idx_valid), .out_last(out_last)
  );

  typedef struct packed {
    logic [N-1:0]    grant;
    logic [G*IW-1:0] idx;
    logic [G-1:0]    iv;
    logic            last;
  } beat_t;

  beat_t mq[$];   // beats still owed by the DUT, front = currently presented
  beat_t got[$];  // beats seen transferring
  beat_t e;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Split a mask into beats: repeatedly take the lowest G set bits.
  function automatic void push_beats(input logic [N-1:0] m);
    logic [N-1:0] rem;
    beat_t b;
    int k;
    rem = m;
    while (rem != '0) begin
      b = '0;
      k = 0;
      for (int i = 0; i < N; i++) begin
        if (rem[i] && k < G) begin
          b.grant[i] = 1'b1;
          b.idx[k*IW +: IW] = i[IW-1:0];
          b.iv[k] = 1'b1;
          k++;
        end
      end
      rem = rem & ~b.grant;
      b.last = (rem == '0);
      mq.push_back(b);
    end
  endfunction

  // Model: accept when nothing is owed, otherwise retire the front beat on ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (in_valid && in_mask != '0) push_beats(in_mask);
    end else if (out_ready) begin
      void'(mq.pop_front());
    end
  end

  // Compare DUT outputs to the model every cycle.
  always @(negedge clk) begin
    if (mq.size() == 0) begin
      chk("cmp_valid", out_valid, 0);
      chk("cmp_ready", in_ready, 1);
      chk("cmp_grant", out_grant, 0);
      chk("cmp_idx", out_idx, 0);
      chk("cmp_iv", out_idx_valid, 0);
      chk("cmp_last", out_last, 0);
    end else begin
      e = mq[0];
      chk("cmp_valid", out_valid, 1);
      chk("cmp_ready", in_ready, 0);
      chk("cmp_grant", out_grant, e.grant);
      chk("cmp_idx", out_idx, e.idx);
      chk("cmp_iv", out_idx_valid, e.iv);
      chk("cmp_last", out_last, e.last);
    end
  end

  // Record every beat that transfers.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back({out_grant, out_idx, out_idx_valid, out_last});
  end

  task automatic send(input logic [N-1:0] m);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_mask  = m;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
      if (done) break;
    end
    chk("accept_in_time", done, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
      if (done) break;
    end
    chk("idle_in_time", done, 1);
  endtask

  task automatic chk_beat(string name, logic [N-1:0] g, logic [G*IW-1:0] idx,
                          logic [G-1:0] iv, logic last);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_grant"}, out_grant, g);
    chk({name, "_idx"}, out_idx, idx);
    chk({name, "_iv"}, out_idx_valid, iv);
    chk({name, "_last"}, out_last, last);
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [3:0] pat;
    logic [N-1:0] prev_grant;
    logic [G*IW-1:0] prev_idx;
    bit prev_stall;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_grant", out_grant, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_iv", out_idx_valid, 0);
    chk("rst_last", out_last, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: sparse mask, ready held high
    out_ready = 1'b1;
    got.delete();
    send(8'hB6);
    @(negedge clk);
    chk("t1_model_beats", mq.size(), 3);
    chk("t1_model_g0", mq[0].grant, 8'h06);
    chk_beat("t1_b1", 8'h06, 6'o21, 2'b11, 1'b0);
    @(negedge clk);
    chk_beat("t1_b2", 8'h30, 6'o54, 2'b11, 1'b0);
    @(negedge clk);
    chk_beat("t1_b3", 8'h80, 6'o07, 2'b01, 1'b1);
    @(negedge clk);
    chk("t1_ready_after", in_ready, 1);
    chk("t1_valid_after", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_nbeats", got.size(), 3);

    // 2: zero mask is swallowed
    got.delete();
    send(8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("t2_valid", out_valid, 0);
      chk("t2_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    chk("t2_nbeats", got.size(), 0);

    // 3: full mask with a 1,0,0,1 ready pattern
    got.delete();
    out_ready = 1'b0;
    send(8'hFF);
    pat = 4'b1001;
    prev_stall = 1'b0;
    prev_grant = '0;
    prev_idx = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      if (prev_stall) begin
        chk("t3_stall_grant", out_grant, prev_grant);
        chk("t3_stall_idx", out_idx, prev_idx);
      end
      prev_stall = out_valid && !out_ready;
      prev_grant = out_grant;
      prev_idx   = out_idx;
      @(posedge clk); #1;
    end
    chk("t3_nbeats", got.size(), 4);
    if (got.size() == 4) begin
      chk("t3_g0", got[0].grant, 8'h03);
      chk("t3_g1", got[1].grant, 8'h0C);
      chk("t3_g2", got[2].grant, 8'h30);
      chk("t3_g3", got[3].grant, 8'hC0);
      chk("t3_l0", got[0].last, 0);
      chk("t3_l1", got[1].last, 0);
      chk("t3_l2", got[2].last, 0);
      chk("t3_l3", got[3].last, 1);
    end
    out_ready = 1'b1;
    wait_idle();

    // 4: single bit
    got.delete();
    send(8'h80);
    @(negedge clk);
    chk_beat("t4_b1", 8'h80, 6'o07, 2'b01, 1'b1);
    @(negedge clk);
    chk("t4_ready_after", in_ready, 1);
    @(posedge clk); #1;
    chk("t4_nbeats", got.size(), 1);

    // 5: reset in the middle of a drain
    send(8'hFF);
    @(negedge clk);
    chk_beat("t5_b1", 8'h03, 6'o10, 2'b11, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ready", in_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    got.delete();
    repeat (5) begin
      @(negedge clk);
      chk("t5_no_residual", out_valid, 0);
    end
    @(posedge clk); #1;
    chk("t5_nbeats", got.size(), 0);

    // 6: back-to-back masks with in_valid held
    got.delete();
    in_valid = 1'b1;
    in_mask  = 8'h05;
    @(negedge clk);
    chk("t6_ready0", in_ready, 1);
    @(posedge clk); #1;
    in_mask = 8'h18;
    @(negedge clk);
    chk("t6_busy", in_ready, 0);
    chk_beat("t6_b1", 8'h05, 6'o20, 2'b11, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_gap_ready", in_ready, 1);
    chk("t6_gap_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_beat("t6_b2", 8'h18, 6'o43, 2'b11, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_ready_end", in_ready, 1);
    @(posedge clk); #1;
    chk("t6_nbeats", got.size(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
